// File: rtl/exc_redirect.sv
// Fetch-side exception/ERET redirect: flush, drain in-flight fetch responses, then steer the PC generator.
// Optional REDIRECT_PERF_EN adds event and stall counters.
module exc_redirect #(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_oc,
    input  logic        wb_eret,
    input  logic [31:0] cp0_epc,
    input  logic        if_req_fire,
    input  logic        if_resp_fire,
    input  logic        if_redirect_ready,
    output logic        flush,
    output logic        discard_resp,
    output logic        req_block,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0] perf_exc_cnt,
    output logic [31:0] perf_eret_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ISSUE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
    logic [31:0]       target_reg, target_next;
    logic              flush_reg;
    logic              evt;
    logic [31:0]       evt_target;

    assign evt        = exc_oc | wb_eret;
    assign evt_target = exc_oc ? EXC_VECTOR : cp0_epc;

    // A response with nothing outstanding is illegal; the count holds at zero.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (if_req_fire && !if_resp_fire) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!if_req_fire && if_resp_fire && (outstanding_reg != '0)) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    // An event in any state restarts the sequence from DRAIN, pre-empting a pending handshake.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        if (evt) begin
            state_next  = ST_DRAIN;
            target_next = evt_target;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_IDLE;
                ST_DRAIN: if (outstanding_next == '0) state_next = ST_ISSUE;
                ST_ISSUE: if (if_redirect_ready) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            outstanding_reg <= '0;
            target_reg      <= '0;
            flush_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            target_reg      <= target_next;
            flush_reg       <= evt;
        end
    end

    assign flush          = flush_reg;
    assign discard_resp   = (state_reg == ST_DRAIN);
    assign redirect_valid = (state_reg == ST_ISSUE);
    assign redirect_pc    = redirect_valid ? target_reg : 32'h0;
    assign req_block      = (outstanding_reg >= CNT_MAX) || (state_reg != ST_IDLE);

`ifdef REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_exc_cnt   <= '0;
            perf_eret_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (exc_oc) perf_exc_cnt <= perf_exc_cnt + 32'd1;
            if (wb_eret && !exc_oc) perf_eret_cnt <= perf_eret_cnt + 32'd1;
            if (state_reg != ST_IDLE) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/exc_redirect.md
Name: exc_redirect

Overview:
- Fetch-side receiver of exception-commit events from the exception-commit stage.
- On an exception commit (exc_oc) or an ERET reaching WB (wb_eret), it flushes the pipeline.
- It then drains in-flight instruction-fetch AXI responses, which are discarded.
- Finally it steers the PC generator to the exception vector or to cp0_epc, holding the redirect until fetch accepts it.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address (BEV=1).
- MAX_OUTSTANDING, 4, max in-flight fetch reads tracked; outstanding counter width is clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- exc_oc  in  1  exception/interrupt committed this cycle (level, 1-cycle pulse per event)
- wb_eret  in  1  ERET retired in WB this cycle
- cp0_epc  in  32  current CP0 EPC, sampled on wb_eret
- if_req_fire  in  1  fetch AR handshake completed this cycle
- if_resp_fire  in  1  fetch R handshake (last beat) completed this cycle
- if_redirect_ready  in  1  PC generator accepts redirect this cycle
- flush  out  1  one-cycle pipeline flush pulse
- discard_resp  out  1  current fetch response must be dropped
- req_block  out  1  fetch must not issue a new AR
- redirect_valid  out  1  redirect target valid
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (resetn=0, async): state=IDLE, outstanding=0, flush=0, redirect_valid=0, redirect_pc=0, discard_resp=0, req_block=0.
- Outstanding counter updates every cycle: +1 on if_req_fire, -1 on if_resp_fire, unchanged when both fire together.
- Decrement at 0 is illegal and holds 0 (assertion in bench).
- req_block=1 whenever outstanding==MAX_OUTSTANDING or state!=IDLE.
- The event of a cycle is exc_oc or wb_eret. Exception has priority: if both are high, target=EXC_VECTOR.
- Target latched at the event: EXC_VECTOR for exc_oc, cp0_epc (same-cycle value) for wb_eret.
- flush is registered: high exactly the cycle after each accepted event, including events re-raised in DRAIN/ISSUE.
- States:
  - IDLE: on event, latch target and go to DRAIN. The count used is post-update, i.e. it includes an if_req_fire in the event cycle.
  - DRAIN: discard_resp=1. Stay while outstanding!=0; go to ISSUE the cycle after outstanding reaches 0. If outstanding==0 on entry, spend exactly one cycle in DRAIN.
  - ISSUE: redirect_valid=1, redirect_pc=target. Hold both stable until if_redirect_ready=1. On the ready cycle, return to IDLE; redirect_valid=0 from the next cycle.
- New event while in DRAIN or ISSUE:
  - Overwrite target, with exception priority.
  - Re-pulse flush.
  - From ISSUE, go back to DRAIN with no handshake completing that cycle, even if if_redirect_ready=1.
- discard_resp is 0 in IDLE and ISSUE.
- if_req_fire in a non-IDLE state is a protocol violation (req_block is high). It is still counted so the responses drain correctly.
- Latency, event to redirect_valid with 0 outstanding: 2 cycles (event cycle, DRAIN, ISSUE).
- Latency with N outstanding: 1 + (cycles until N responses) + 1.

Optional Feature:
- Macro REDIRECT_PERF_EN.
- Defined:
  - Adds outputs perf_exc_cnt[31:0], perf_eret_cnt[31:0], perf_stall_cnt[31:0].
  - perf_exc_cnt and perf_eret_cnt count accepted events of each type. A simultaneous exc_oc+wb_eret counts as exception only.
  - perf_stall_cnt counts cycles with state!=IDLE.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent, core behaviour identical.

Test Plan:
- Idle exception: outstanding=0, pulse exc_oc at T.
  - Expect flush=1 at T+1, redirect_valid=1 at T+2 with redirect_pc=32'hBFC00380.
  - Ready at T+3 → redirect_valid=0 at T+4.
- ERET with drain: 2 fetches in flight, cp0_epc=32'h8000_1234, wb_eret at T, responses at T+3 and T+5.
  - Expect discard_resp=1 from T+1 to T+5, redirect_valid at T+6 with pc=32'h8000_1234.
- Simultaneous: exc_oc=1 and wb_eret=1 in the same cycle → target 32'hBFC00380.
  - With REDIRECT_PERF_EN: perf_exc_cnt=1, perf_eret_cnt=0.
- Override in ISSUE: ERET redirect held with if_redirect_ready=0, then exc_oc.
  - Expect a second flush pulse, return to DRAIN, final redirect_pc=32'hBFC00380, and no handshake on the EPC target.
- Saturation: MAX_OUTSTANDING=4, 4 req fires with no responses → req_block=1; one response → req_block=0 the same cycle the counter reads 3.
- Reset mid-DRAIN: deassert resetn with 2 outstanding → all outputs 0 immediately (async).
  - After release: state=IDLE, outstanding=0, no spurious flush.
